// File: rtl/zx_mem_pkg.sv
// zx_mem_pkg: shared RAM constants and the read-return tag encoding used by the arbiter.
package zx_mem_pkg;
  localparam int RAM_ADDR_W = 15;
  localparam int STARVE_CNT_W = 4;
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_LDR  = 2'd2,
    TAG_CPU  = 2'd3
  } tag_e;
endpackage

// File: rtl/zx_ram_arbiter_if.sv
// zx_ram_arbiter_if: requester (vid/ldr/cpu req, addr, we, wdata, ack, rvalid, rdata) and RAM (we, addr, din, dout) bus; slave = arbiter side, master = requesters/RAM side.
interface zx_ram_arbiter_if
  import zx_mem_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [7:0]        vid_rdata;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_wdata;
  logic              ldr_ack;
  logic              ldr_rvalid;
  logic [7:0]        ldr_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  modport slave (
    input  vid_req, vid_addr,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ram_dout,
    output vid_ack, vid_rvalid, vid_rdata,
    output ldr_ack, ldr_rvalid, ldr_rdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    output ram_we, ram_addr, ram_din
  );
  modport master (
    output vid_req, vid_addr,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ram_dout,
    input  vid_ack, vid_rvalid, vid_rdata,
    input  ldr_ack, ldr_rvalid, ldr_rdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    input  ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/zx_ram_prio_sel.sv
// zx_ram_prio_sel: combinational priority select (vid > starved cpu > ldr > cpu); ins vid/ldr/cpu req + starved, out one-hot gnt {cpu, ldr, vid}.
module zx_ram_prio_sel (
  input  logic       vid_req,
  input  logic       ldr_req,
  input  logic       cpu_req,
  input  logic       starved,
  output logic [2:0] gnt
);
  always_comb begin
    gnt[0] = vid_req;
    gnt[1] = !vid_req && ldr_req && !(cpu_req && starved);
    gnt[2] = !vid_req && cpu_req && (starved || !ldr_req);
  end
endmodule

// File: rtl/zx_ram_arbiter.sv
// zx_ram_arbiter: shares one single-port RAM among video, loader and CPU; ports clk, reset, bus (slave: requester handshakes in, RAM pins out, read data back).
module zx_ram_arbiter
  import zx_mem_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  zx_ram_arbiter_if.slave  bus
);
  logic [2:0]              gnt_raw;
  logic [2:0]              gnt;
  logic                    starved;
  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  tag_e                    tag_q, tag_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [7:0]              din_q, din_d;
  logic [7:0]              vid_rd_q, vid_rd_d;
  logic [7:0]              ldr_rd_q, ldr_rd_d;
  logic [7:0]              cpu_rd_q, cpu_rd_d;
  logic                    vid_rv, ldr_rv, cpu_rv;
  assign starved = cnt_q >= STARVE_CNT_W'(STARVE_MAX);
  zx_ram_prio_sel u_sel (
    .vid_req (bus.vid_req),
    .ldr_req (bus.ldr_req),
    .cpu_req (bus.cpu_req),
    .starved (starved),
    .gnt     (gnt_raw)
  );
  always_comb begin
    gnt = reset ? 3'b000 : gnt_raw;
    addr_d = reset ? '0 : gnt[0] ? bus.vid_addr : gnt[1] ? bus.ldr_addr : gnt[2] ? bus.cpu_addr : addr_q;
    din_d = reset ? '0 : gnt[1] ? bus.ldr_wdata : gnt[2] ? bus.cpu_wdata : din_q;
    tag_d = gnt[0] ? TAG_VID : (gnt[1] && !bus.ldr_we) ? TAG_LDR : (gnt[2] && !bus.cpu_we) ? TAG_CPU : TAG_NONE;
    cnt_d = (reset || !bus.cpu_req || gnt[2]) ? '0 : (cnt_q == '1) ? cnt_q : cnt_q + STARVE_CNT_W'(1);
    vid_rv = !reset && tag_q == TAG_VID;
    ldr_rv = !reset && tag_q == TAG_LDR;
    cpu_rv = !reset && tag_q == TAG_CPU;
    vid_rd_d = reset ? '0 : vid_rv ? bus.ram_dout : vid_rd_q;
    ldr_rd_d = reset ? '0 : ldr_rv ? bus.ram_dout : ldr_rd_q;
    cpu_rd_d = reset ? '0 : cpu_rv ? bus.ram_dout : cpu_rd_q;
    bus.vid_ack = gnt[0];
    bus.ldr_ack = gnt[1];
    bus.cpu_ack = gnt[2];
    bus.ram_we = (gnt[1] && bus.ldr_we) || (gnt[2] && bus.cpu_we);
    bus.ram_addr = addr_d;
    bus.ram_din = din_d;
    bus.vid_rvalid = vid_rv;
    bus.ldr_rvalid = ldr_rv;
    bus.cpu_rvalid = cpu_rv;
    bus.vid_rdata = vid_rv ? bus.ram_dout : vid_rd_q;
    bus.ldr_rdata = ldr_rv ? bus.ram_dout : ldr_rd_q;
    bus.cpu_rdata = cpu_rv ? bus.ram_dout : cpu_rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      tag_q    <= TAG_NONE;
      addr_q   <= '0;
      din_q    <= '0;
      vid_rd_q <= '0;
      ldr_rd_q <= '0;
      cpu_rd_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      vid_rd_q <= vid_rd_d;
      ldr_rd_q <= ldr_rd_d;
      cpu_rd_q <= cpu_rd_d;
    end
  end
endmodule

// File: doc/zx_ram_arbiter.md
Name: zx_ram_arbiter

Overview:
- Shares the single-port 32 KB SPRAM main memory (one access per clock, 1-cycle registered read data) between three requesters: ULA video fetch, snapshot/tape loader, and the Z80 CPU.
- Sits between the requesters and the ZX RAM wrapper, and drives that wrapper's we/addr/din pins.
- Uses fixed priority with a starvation guard for the CPU, and returns read data to the requester that issued the access.

Parameters:
ADDR_W, 15, RAM byte-address width (32 KB).
STARVE_MAX, 4, cycles the CPU may wait with req high before it outranks the loader (1..15).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vid_req  in  1  video read request (read-only port)
vid_addr  in  ADDR_W  video byte address
vid_ack  out  1  video request accepted this cycle
vid_rvalid  out  1  vid_rdata valid
vid_rdata  out  8  video read data
ldr_req  in  1  loader request
ldr_we  in  1  loader write when 1, read when 0
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  8  loader write data
ldr_ack  out  1  loader accepted
ldr_rvalid  out  1  loader read data valid
ldr_rdata  out  8  loader read data
cpu_req  in  1  CPU request
cpu_we  in  1  CPU write
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  CPU accepted
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  8  CPU read data
ram_we  out  1  to RAM write enable
ram_addr  out  ADDR_W  to RAM address
ram_din  out  8  to RAM write data
ram_dout  in  8  from RAM; valid 1 cycle after the address is presented

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset. Everything is sampled on rising clk.
- Grant per cycle:
  - The arbiter chooses one requester combinationally from the current req inputs.
  - It drives ram_addr, ram_we and ram_din from that requester in the same cycle.
  - It asserts that requester's ack for exactly that cycle.
  - With no request, ram_we=0 and ram_addr/ram_din hold their last values. No access tag is issued.
- Handshake: a requester holds req, addr, we and wdata stable until it sees ack high. ack implies the access took place. The requester may deassert req, or present a new request, in the cycle after ack.
- Priority: video > CPU(starved) > loader > CPU.
  - The video port is never blocked, so ULA timing stays deterministic.
- Starvation counter (4 bits):
  - Counts +1 for each cycle with cpu_req=1 and cpu_ack=0, saturating at 15.
  - Clears when cpu_ack=1 or cpu_req=0.
  - The CPU is "starved" when counter >= STARVE_MAX.
- Read return:
  - A 2-bit tag register records the granted requester (NONE/VID/LDR/CPU) and whether the access was a read.
  - In the next cycle, ram_dout is routed to that requester's rdata and its rvalid is pulsed for 1 cycle.
  - Read latency is ack -> rvalid = 1 cycle.
  - Writes produce no rvalid.
  - Back-to-back grants give one rvalid per cycle, pipelined.
- Holding: each rdata register holds its last value until the next rvalid for that port.
- Reset values:
  - All ack and rvalid outputs = 0; all rdata = 0.
  - ram_we = 0, ram_addr = 0, ram_din = 0 (an address/data register is used when idle).
  - Tag = NONE; starvation counter = 0.
- Reset mid-operation:
  - A pending tag is discarded: no rvalid in the cycle after reset.
  - The RAM write in the reset cycle is suppressed: ram_we is forced 0 while reset=1.
  - Acks are forced 0 while reset=1.
- Simultaneous events:
  - With all three requesting, video wins.
  - With loader and non-starved CPU requesting, the loader wins.
  - A rvalid for the previous access may coincide with a new ack on any port.
- Address wrap: addresses are used modulo 2^ADDR_W. There is no bounds checking.

Decomposition:
- Shared package zx_mem_pkg holds:
  - the tag encoding (TAG_NONE=0, TAG_VID=1, TAG_LDR=2, TAG_CPU=3);
  - localparam RAM_ADDR_W=15;
  - STARVE_CNT_W=4.
- One natural sub-module, zx_ram_prio_sel: a purely combinational priority select that takes the three reqs plus the starved flag and returns a one-hot grant.
- Counter, tag pipeline and data return stay in the top module.

Test Plan:
- Reset release, then CPU write 0x5A to 0x1234, then CPU read 0x1234:
  - the write gives cpu_ack for 1 cycle with ram_we=1 and ram_addr=0x1234;
  - the read gives cpu_rvalid exactly 1 cycle after its ack, with cpu_rdata=0x5A.
- vid_req and cpu_req (read) both raised in the same cycle, addresses 0x4000/0x0100:
  - vid_ack comes first and vid_rvalid follows 1 cycle later;
  - cpu_ack comes the cycle after vid_ack;
  - each rdata is routed to the correct port.
- ldr_req held high continuously (write burst) with cpu_req high, STARVE_MAX=4:
  - loader acks for 4 cycles;
  - cpu_ack in cycle 5;
  - loader resumes in cycle 6.
- Pipelined reads alternating VID/LDR/CPU every cycle for 6 cycles:
  - exactly one rvalid per cycle, on the correct port, data matching a preloaded memory model;
  - no rvalid follows a write.
- reset asserted in the same cycle as cpu_req with cpu_we=1, addr 0x0010, data 0xFF:
  - no cpu_ack and ram_we=0;
  - a subsequent read of 0x0010 returns its pre-reset contents;
  - no stray rvalid in the cycle after reset.
- Idle for 10 cycles after traffic:
  - all acks and rvalids stay 0, ram_we=0;
  - rdata outputs hold their last values.
